fetch_ctrl: RTL and testbench

Sequencer for the core's program counter and instruction-fetch port. It owns the architectural PC and runs one instruction fetch at a time over a req/ack memory handshake. It holds each fetched instruction for the execute stage until that stage consumes it, then chooses the next fetch address from the branch, trap, flush and sequential sources. It sits between the instruction memory interface and decode/execute, and captures the exception PC and cause when a trap or a misaligned branch occurs.

---
 rtl/fetch_ctrl_pkg.sv | 38 +++
 rtl/fetch_ctrl_carry_lookahead_adder.sv | 46 ++++
 rtl/fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants, state encoding and trap decode helpers for the fetch sequencer.
// Trap codes 3'b001..3'b011 are the existing core-wide codes; 3'b100/3'b101 extend them.
package fetch_ctrl_pkg;

    localparam logic [31:0] RESET_ADDR       = 32'h0000_0000;
    localparam logic [31:0] VEC_BR_MISALIGN  = 32'd1020;
    localparam logic [31:0] VEC_ECALL        = 32'd2050;
    localparam logic [31:0] VEC_EBREAK       = 32'd2051;
    localparam logic [31:0] VEC_MEM_MISALIGN = 32'd2052;

    localparam logic [2:0] TRAP_NONE    = 3'b000;
    localparam logic [2:0] E_CALL       = 3'b001;
    localparam logic [2:0] E_BREAK      = 3'b010;
    localparam logic [2:0] MEM_MISALIGN = 3'b011;
    localparam logic [2:0] TRAP_REPLAY  = 3'b100;
    localparam logic [2:0] BR_MISALIGN  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_VALID = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    function automatic logic is_vectored_trap(input logic [2:0] code);
        return (code == E_CALL) || (code == E_BREAK) || (code == MEM_MISALIGN);
    endfunction

    function automatic logic [31:0] trap_vector(input logic [2:0] code);
        case (code)
            E_CALL:       return VEC_ECALL;
            E_BREAK:      return VEC_EBREAK;
            MEM_MISALIGN: return VEC_MEM_MISALIGN;
            default:      return RESET_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/fetch_ctrl_carry_lookahead_adder.sv
// Adder built from 4-bit lookahead groups chained by group generate/propagate.
// WIDTH must be a multiple of 4; o_sum[WIDTH] is the carry out.
module carry_lookahead_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH:0]   o_sum
);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [3:0]       w_grp_g;
    logic [3:0]       w_grp_p;
    logic             w_c0;
    logic             w_c1;
    logic             w_c2;
    logic             w_c3;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        o_sum   = '0;
        w_grp_g = '0;
        w_grp_p = '0;
        w_c0    = i_cin;
        w_c1    = 1'b0;
        w_c2    = 1'b0;
        w_c3    = 1'b0;
        for (int k = 0; k < WIDTH / 4; k++) begin
            w_grp_g = w_g[k*4 +: 4];
            w_grp_p = w_p[k*4 +: 4];
            w_c1 = w_grp_g[0] | (w_grp_p[0] & w_c0);
            w_c2 = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0]) | (w_grp_p[1] & w_grp_p[0] & w_c0);
            w_c3 = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1]) | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                 | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & w_c0);
            o_sum[k*4 +: 4] = w_grp_p ^ {w_c3, w_c2, w_c1, w_c0};
            w_c0 = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2]) | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
                 | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0]) | ((&w_grp_p) & w_c0);
        end
        o_sum[WIDTH] = w_c0;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and single-outstanding instruction fetch sequencer.
//   state | meaning
//   IDLE  | first cycle after reset, no request
//   FETCH | request outstanding at r_fetch_addr
//   VALID | instruction held for execute
//   DRAIN | request outstanding whose data will be discarded
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_r_instr,
    output logic [31:0] o_r_pc,
    input  logic        i_stall,
    input  logic        i_is_branch_true,
    input  logic [31:0] i_branch_addr,
    input  logic [2:0]  i_trap,
    input  logic        i_flush,
    input  logic [31:0] i_flush_addr,
    output logic [31:0] o_r_epc,
    output logic [2:0]  o_r_cause
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_addr;
    logic [31:0] w_fetch_addr_nxt;
    logic [31:0] r_drain_addr;
    logic [31:0] w_drain_addr_nxt;
    logic [31:0] w_drain_target;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic [2:0]  r_cause;
    logic        w_capture;
    logic        w_rec_trap;
    logic [2:0]  w_rec_cause;

    logic [31:0] w_consume_addr;
    logic        w_consume_rec;
    logic [2:0]  w_consume_cause;
    logic        w_br_misalign;

    logic [32:0] w_pc_sum;
    logic [31:0] w_pc_plus4;
    logic        w_unused_carry;

    carry_lookahead_adder #(
        .WIDTH (32)
    ) u_pc_adder (
        .i_a   (r_pc),
        .i_b   (32'd4),
        .i_cin (1'b0),
        .o_sum (w_pc_sum)
    );

    // pc+4 wraps: the carry out is intentionally dropped.
    assign w_pc_plus4     = w_pc_sum[31:0];
    assign w_unused_carry = w_pc_sum[32];

    assign w_br_misalign = i_is_branch_true && (i_branch_addr[1:0] != 2'b00);

    always_comb begin
        w_consume_addr  = w_pc_plus4;
        w_consume_rec   = 1'b0;
        w_consume_cause = r_cause;
        if (w_br_misalign) begin
            w_consume_addr  = VEC_BR_MISALIGN;
            w_consume_rec   = 1'b1;
            w_consume_cause = BR_MISALIGN;
        end else if (i_is_branch_true) begin
            w_consume_addr = i_branch_addr;
        end else if (is_vectored_trap(i_trap)) begin
            w_consume_addr  = trap_vector(i_trap);
            w_consume_rec   = 1'b1;
            w_consume_cause = i_trap;
        end else if (i_trap == TRAP_REPLAY) begin
            w_consume_addr = r_pc;
        end
    end

    // A flush arriving while draining replaces the pending redirect target.
    assign w_drain_target = i_flush ? i_flush_addr : r_drain_addr;

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_addr_nxt = r_fetch_addr;
        w_drain_addr_nxt = r_drain_addr;
        w_capture        = 1'b0;
        w_rec_trap       = 1'b0;
        w_rec_cause      = r_cause;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt      = ST_FETCH;
                w_fetch_addr_nxt = i_flush ? i_flush_addr : RESET_ADDR;
            end
            ST_FETCH: begin
                if (i_imem_ack) begin
                    if (i_flush) begin
                        w_fetch_addr_nxt = i_flush_addr;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_VALID;
                    end
                end else if (i_flush) begin
                    w_drain_addr_nxt = i_flush_addr;
                    w_state_nxt      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_drain_addr_nxt = w_drain_target;
                if (i_imem_ack) begin
                    w_fetch_addr_nxt = w_drain_target;
                    w_state_nxt      = ST_FETCH;
                end
            end
            ST_VALID: begin
                if (i_flush) begin
                    w_fetch_addr_nxt = i_flush_addr;
                    w_state_nxt      = ST_FETCH;
                end else if (!i_stall) begin
                    w_fetch_addr_nxt = w_consume_addr;
                    w_rec_trap       = w_consume_rec;
                    w_rec_cause      = w_consume_cause;
                    w_state_nxt      = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_fetch_addr <= RESET_ADDR;
            r_drain_addr <= RESET_ADDR;
            r_instr      <= '0;
            r_pc         <= '0;
            r_epc        <= '0;
            r_cause      <= TRAP_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_addr <= w_fetch_addr_nxt;
            r_drain_addr <= w_drain_addr_nxt;
            if (w_capture) begin
                r_instr <= i_imem_rdata;
                r_pc    <= r_fetch_addr;
            end
            if (w_rec_trap) begin
                r_epc   <= r_pc;
                r_cause <= w_rec_cause;
            end
        end
    end

    assign o_imem_req    = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign o_imem_addr   = r_fetch_addr;
    assign o_instr_valid = (r_state == ST_VALID);
    assign o_r_instr     = r_instr;
    assign o_r_pc        = r_pc;
    assign o_r_epc       = r_epc;
    assign o_r_cause     = r_cause;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// transaction-level run against a next-address/epc model.
module tb_fetch_ctrl;

    localparam logic [31:0] V_BR   = 32'd1020;
    localparam logic [31:0] V_CALL = 32'd2050;
    localparam logic [31:0] V_BRK  = 32'd2051;
    localparam logic [31:0] V_MEM  = 32'd2052;
    localparam logic [2:0]  T_CALL = 3'b001;
    localparam logic [2:0]  T_BRK  = 3'b010;
    localparam logic [2:0]  T_MEM  = 3'b011;
    localparam logic [2:0]  T_RPL  = 3'b100;
    localparam logic [2:0]  T_BRMA = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        o_instr_valid;
    logic [31:0] o_r_instr;
    logic [31:0] o_r_pc;
    logic        i_stall;
    logic        i_is_branch_true;
    logic [31:0] i_branch_addr;
    logic [2:0]  i_trap;
    logic        i_flush;
    logic [31:0] i_flush_addr;
    logic [31:0] o_r_epc;
    logic [2:0]  o_r_cause;

    logic        auto_ack;
    logic        tb_ack;
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m_epc;
    logic [2:0]  m_cause;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign i_imem_ack   = auto_ack ? o_imem_req : tb_ack;
    assign i_imem_rdata = mem_word(o_imem_addr);

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_ack       (i_imem_ack),
        .i_imem_rdata     (i_imem_rdata),
        .o_instr_valid    (o_instr_valid),
        .o_r_instr        (o_r_instr),
        .o_r_pc           (o_r_pc),
        .i_stall          (i_stall),
        .i_is_branch_true (i_is_branch_true),
        .i_branch_addr    (i_branch_addr),
        .i_trap           (i_trap),
        .i_flush          (i_flush),
        .i_flush_addr     (i_flush_addr),
        .o_r_epc          (o_r_epc),
        .o_r_cause        (o_r_cause)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!o_instr_valid && k < 40) begin
            tick();
            k++;
        end
        n_total++;
        if (!o_instr_valid) $display("FAIL %s: instr_valid never rose (actual 0, required 1)", tag);
        else n_pass++;
    endtask

    task automatic goto_pc(input logic [31:0] a);
        auto_ack = 1'b1;
        i_stall  = 1'b1;
        wait_valid("goto_pre");
        i_flush      = 1'b1;
        i_flush_addr = a;
        tick();
        i_flush = 1'b0;
        wait_valid("goto_post");
        n_total++;
        if (o_r_pc !== a) $display("FAIL goto_pc: pc=%h required %h", o_r_pc, a);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_total++;
        if ({o_imem_req, o_instr_valid} !== 2'b00)
            $display("FAIL reset_ctl: req/valid=%b required 00", {o_imem_req, o_instr_valid});
        else n_pass++;
        n_total++;
        if ({o_imem_addr, o_r_instr, o_r_pc, o_r_epc} !== 128'd0)
            $display("FAIL reset_regs: addr=%h instr=%h pc=%h epc=%h required all 0",
                     o_imem_addr, o_r_instr, o_r_pc, o_r_epc);
        else n_pass++;
        n_total++;
        if (o_r_cause !== 3'd0) $display("FAIL reset_cause: %0d required 0", o_r_cause);
        else n_pass++;
    endtask

    task automatic test_sequential();
        i_stall  = 1'b0;
        auto_ack = 1'b1;
        rst_n    = 1'b1;
        n_total++;
        if ({o_imem_req, o_instr_valid} !== 2'b00)
            $display("FAIL seq_c1: req/valid=%b required 00", {o_imem_req, o_instr_valid});
        else n_pass++;
        for (int c = 2; c <= 7; c++) begin
            tick();
            if (c % 2 == 0) begin
                n_total++;
                if (o_imem_req !== 1'b1 || o_instr_valid !== 1'b0 || o_imem_addr !== 32'((c / 2 - 1) * 4))
                    $display("FAIL seq_fetch c%0d: req=%b valid=%b addr=%h required 1 0 %h",
                             c, o_imem_req, o_instr_valid, o_imem_addr, 32'((c / 2 - 1) * 4));
                else n_pass++;
            end else begin
                n_total++;
                if (o_instr_valid !== 1'b1 || o_r_pc !== 32'((c - 3) / 2 * 4) ||
                    o_r_instr !== mem_word(32'((c - 3) / 2 * 4)))
                    $display("FAIL seq_valid c%0d: valid=%b pc=%h instr=%h required 1 %h %h",
                             c, o_instr_valid, o_r_pc, o_r_instr, 32'((c - 3) / 2 * 4),
                             mem_word(32'((c - 3) / 2 * 4)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall_trap();
        goto_pc(32'h40);
        i_trap = T_CALL;
        for (int s = 0; s < 3; s++) begin
            tick();
            n_total++;
            if (o_instr_valid !== 1'b1 || o_imem_req !== 1'b0 || o_r_instr !== mem_word(32'h40))
                $display("FAIL stall_hold %0d: valid=%b req=%b instr=%h required 1 0 %h",
                         s, o_instr_valid, o_imem_req, o_r_instr, mem_word(32'h40));
            else n_pass++;
        end
        i_stall = 1'b0;
        tick();
        i_stall = 1'b1;
        i_trap  = 3'd0;
        m_epc   = 32'h40;
        m_cause = T_CALL;
        n_total++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== V_CALL)
            $display("FAIL ecall_fetch: req=%b addr=%h required 1 %h", o_imem_req, o_imem_addr, V_CALL);
        else n_pass++;
        n_total++;
        if (o_r_epc !== m_epc || o_r_cause !== m_cause)
            $display("FAIL ecall_rec: epc=%h cause=%0d required %h %0d", o_r_epc, o_r_cause, m_epc, m_cause);
        else n_pass++;
    endtask

    task automatic test_branch();
        goto_pc(32'h80);
        i_is_branch_true = 1'b1;
        i_branch_addr    = 32'h102;
        i_stall          = 1'b0;
        tick();
        i_stall          = 1'b1;
        i_is_branch_true = 1'b0;
        m_epc   = 32'h80;
        m_cause = T_BRMA;
        n_total++;
        if (o_imem_addr !== V_BR || o_r_epc !== m_epc || o_r_cause !== m_cause)
            $display("FAIL br_misalign: addr=%h epc=%h cause=%0d required %h %h %0d",
                     o_imem_addr, o_r_epc, o_r_cause, V_BR, m_epc, m_cause);
        else n_pass++;
        wait_valid("br_vec");
        i_is_branch_true = 1'b1;
        i_branch_addr    = 32'h100;
        i_trap           = T_BRK;
        i_stall          = 1'b0;
        tick();
        i_stall          = 1'b1;
        i_is_branch_true = 1'b0;
        i_trap           = 3'd0;
        n_total++;
        if (o_imem_addr !== 32'h100 || o_r_epc !== m_epc || o_r_cause !== m_cause)
            $display("FAIL br_taken: addr=%h epc=%h cause=%0d required 100 %h %0d",
                     o_imem_addr, o_r_epc, o_r_cause, m_epc, m_cause);
        else n_pass++;
    endtask

    task automatic test_flush_drain();
        goto_pc(32'h1C);
        auto_ack = 1'b0;
        tb_ack   = 1'b0;
        i_stall  = 1'b0;
        tick();
        i_stall = 1'b1;
        for (int s = 0; s < 4; s++) begin
            n_total++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h20 || o_instr_valid !== 1'b0)
                $display("FAIL drain_hold %0d: req=%b addr=%h valid=%b required 1 20 0",
                         s, o_imem_req, o_imem_addr, o_instr_valid);
            else n_pass++;
            if (s == 0) begin
                i_flush      = 1'b1;
                i_flush_addr = 32'h300;
            end
            if (s < 3) tick();
            i_flush = 1'b0;
        end
        tb_ack = 1'b1;
        tick();
        tb_ack = 1'b0;
        n_total++;
        if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h300)
            $display("FAIL drain_redirect: valid=%b req=%b addr=%h required 0 1 300",
                     o_instr_valid, o_imem_req, o_imem_addr);
        else n_pass++;
        auto_ack = 1'b1;
        wait_valid("drain_done");
        n_total++;
        if (o_r_pc !== 32'h300 || o_r_instr !== mem_word(32'h300))
            $display("FAIL drain_data: pc=%h instr=%h required 300 %h", o_r_pc, o_r_instr, mem_word(32'h300));
        else n_pass++;
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        i_stall = 1'b0;
        tick();
        i_stall = 1'b1;
        n_total++;
        if (o_imem_addr !== 32'h0 || o_r_epc !== m_epc)
            $display("FAIL wrap: addr=%h epc=%h required 0 %h", o_imem_addr, o_r_epc, m_epc);
        else n_pass++;
        goto_pc(32'hFFFF_FFFC);
        i_trap  = T_RPL;
        i_stall = 1'b0;
        tick();
        i_stall = 1'b1;
        i_trap  = 3'd0;
        n_total++;
        if (o_imem_addr !== 32'hFFFF_FFFC || o_r_epc !== m_epc || o_r_cause !== m_cause)
            $display("FAIL replay: addr=%h epc=%h cause=%0d required fffffffc %h %0d",
                     o_imem_addr, o_r_epc, o_r_cause, m_epc, m_cause);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        goto_pc(32'h500);
        auto_ack = 1'b0;
        tb_ack   = 1'b0;
        i_stall  = 1'b0;
        tick();
        i_stall      = 1'b1;
        i_flush      = 1'b1;
        i_flush_addr = 32'h600;
        tick();
        i_flush = 1'b0;
        n_total++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h504)
            $display("FAIL pre_rst_drain: req=%b addr=%h required 1 504", o_imem_req, o_imem_addr);
        else n_pass++;
        rst_n = 1'b0;
        #2;
        n_total++;
        if ({o_imem_req, o_instr_valid} !== 2'b00 || {o_imem_addr, o_r_instr, o_r_pc, o_r_epc} !== 128'd0 ||
            o_r_cause !== 3'd0)
            $display("FAIL async_rst: req=%b valid=%b addr=%h pc=%h epc=%h cause=%0d required all 0",
                     o_imem_req, o_instr_valid, o_imem_addr, o_r_pc, o_r_epc, o_r_cause);
        else n_pass++;
        tick();
        rst_n    = 1'b1;
        auto_ack = 1'b1;
        m_epc    = 32'h0;
        m_cause  = 3'd0;
        tick();
        n_total++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0)
            $display("FAIL rst_refetch: req=%b addr=%h required 1 0", o_imem_req, o_imem_addr);
        else n_pass++;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC;
        return $urandom() & 32'hFFFF_FFFC;
    endfunction

    task automatic test_random();
        logic [31:0] exp_addr;
        logic [31:0] faddr;
        logic [31:0] cur_pc;
        logic [31:0] baddr;
        logic        flushed;
        logic        br;
        logic [2:0]  trap;
        goto_pc(32'h1000);
        auto_ack = 1'b0;
        tb_ack   = 1'b0;
        i_stall  = 1'b0;
        tick();
        i_stall  = 1'b1;
        exp_addr = 32'h1004;
        faddr    = 32'h0;
        for (int it = 0; it < 150; it++) begin
            n_total++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== exp_addr)
                $display("FAIL rnd_req it%0d: req=%b addr=%h required 1 %h", it, o_imem_req, o_imem_addr, exp_addr);
            else n_pass++;
            flushed = 1'b0;
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                if ($urandom_range(0, 7) == 0) begin
                    faddr = rand_addr(); i_flush = 1'b1; i_flush_addr = faddr; flushed = 1'b1;
                end
                tick();
                i_flush = 1'b0;
                n_total++;
                if (o_imem_req !== 1'b1 || o_imem_addr !== exp_addr || o_instr_valid !== 1'b0)
                    $display("FAIL rnd_wait it%0d: req=%b addr=%h valid=%b required 1 %h 0",
                             it, o_imem_req, o_imem_addr, o_instr_valid, exp_addr);
                else n_pass++;
            end
            tb_ack = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                faddr = rand_addr(); i_flush = 1'b1; i_flush_addr = faddr; flushed = 1'b1;
            end
            tick();
            tb_ack  = 1'b0;
            i_flush = 1'b0;
            if (flushed) begin
                n_total++;
                if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== faddr)
                    $display("FAIL rnd_flush it%0d: valid=%b req=%b addr=%h required 0 1 %h",
                             it, o_instr_valid, o_imem_req, o_imem_addr, faddr);
                else n_pass++;
                exp_addr = faddr;
                continue;
            end
            cur_pc = exp_addr;
            n_total++;
            if (o_instr_valid !== 1'b1 || o_r_pc !== cur_pc || o_r_instr !== mem_word(cur_pc))
                $display("FAIL rnd_data it%0d: valid=%b pc=%h instr=%h required 1 %h %h",
                         it, o_instr_valid, o_r_pc, o_r_instr, cur_pc, mem_word(cur_pc));
            else n_pass++;
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
                i_is_branch_true = 1'($urandom_range(0, 1));
                i_branch_addr    = $urandom();
                i_trap           = 3'($urandom_range(0, 7));
                tick();
                n_total++;
                if (o_instr_valid !== 1'b1 || o_imem_req !== 1'b0 || o_r_instr !== mem_word(cur_pc))
                    $display("FAIL rnd_stall it%0d: valid=%b req=%b instr=%h required 1 0 %h",
                             it, o_instr_valid, o_imem_req, o_r_instr, mem_word(cur_pc));
                else n_pass++;
            end
            br    = ($urandom_range(0, 3) == 0);
            baddr = $urandom();
            trap  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            i_is_branch_true = br;
            i_branch_addr    = baddr;
            i_trap           = trap;
            if ($urandom_range(0, 9) == 0) begin
                faddr = rand_addr(); i_flush = 1'b1; i_flush_addr = faddr;
                exp_addr = faddr;
            end else if (br && baddr[1:0] != 2'b00) begin
                exp_addr = V_BR; m_epc = cur_pc; m_cause = T_BRMA;
            end else if (br) begin
                exp_addr = baddr;
            end else if (trap == T_CALL || trap == T_BRK || trap == T_MEM) begin
                exp_addr = (trap == T_CALL) ? V_CALL : (trap == T_BRK) ? V_BRK : V_MEM;
                m_epc = cur_pc; m_cause = trap;
            end else if (trap == T_RPL) begin
                exp_addr = cur_pc;
            end else begin
                exp_addr = cur_pc + 32'd4;
            end
            i_stall = 1'b0;
            tick();
            i_stall = 1'b1; i_flush = 1'b0; i_is_branch_true = 1'b0; i_trap = 3'd0;
            n_total++;
            if (o_r_epc !== m_epc || o_r_cause !== m_cause)
                $display("FAIL rnd_epc it%0d: epc=%h cause=%0d required %h %0d", it, o_r_epc, o_r_cause, m_epc, m_cause);
            else n_pass++;
        end
        n_total++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== exp_addr)
            $display("FAIL rnd_final: req=%b addr=%h required 1 %h", o_imem_req, o_imem_addr, exp_addr);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        auto_ack         = 1'b1;
        tb_ack           = 1'b0;
        i_stall          = 1'b1;
        i_is_branch_true = 1'b0;
        i_branch_addr    = 32'h0;
        i_trap           = 3'd0;
        i_flush          = 1'b0;
        i_flush_addr     = 32'h0;
        m_epc            = 32'h0;
        m_cause          = 3'd0;
        test_reset();
        test_sequential();
        test_stall_trap();
        test_branch();
        test_flush_drain();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
